// File: rtl/ni_csr_irq_ctrl.sv
// ni_csr_irq_ctrl
//   CSR block and interrupt controller for one network interface. A
//   single-outstanding request/response channel reaches the control
//   registers. Per-VC read-buffer conditions become edge-detected sticky
//   status bits, which are masked and coalesced into one interrupt line.
//
// Ports
//   clk_axi, arst_axi_n   : clock, asynchronous active-low reset
//   req_*                 : request channel (valid/ready, wr, byte address, wdata)
//   resp_*                : response channel (valid/ready, rdata, error)
//   empty_i, full_i       : per-VC read-buffer flags
//   ocup_i                : per-VC occupancy, OCUP_WIDTH bits per VC
//   pkt_size_i            : per-VC head packet size, PKT_WIDTH bits per VC
//   irq_vcs_o             : masked pending status per VC
//   irq_o                 : coalesced interrupt
module ni_csr_irq_ctrl #(
  parameter int          NUM_VC      = 4,
  parameter int          OCUP_WIDTH  = 16,
  parameter int          PKT_WIDTH   = 8,
  parameter int          TIMER_WIDTH = 16,
  parameter logic [15:0] ROUTER_X_ID = 16'd0,
  parameter logic [15:0] ROUTER_Y_ID = 16'd0,
  parameter logic [31:0] VERSION     = 32'h0002_0000
) (
  input  logic                           clk_axi,
  input  logic                           arst_axi_n,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_wr_i,
  input  logic [15:0]                    req_addr_i,
  input  logic [31:0]                    req_wdata_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic [31:0]                    resp_rdata_o,
  output logic                           resp_error_o,
  input  logic [NUM_VC-1:0]              empty_i,
  input  logic [NUM_VC-1:0]              full_i,
  input  logic [NUM_VC*OCUP_WIDTH-1:0]   ocup_i,
  input  logic [NUM_VC*PKT_WIDTH-1:0]    pkt_size_i,
  output logic [NUM_VC-1:0]              irq_vcs_o,
  output logic                           irq_o
);

  typedef enum logic [1:0] {
    MODE_NOT_EMPTY = 2'd0,
    MODE_FULL      = 2'd1,
    MODE_THRESH    = 2'd2,
    MODE_RSVD      = 2'd3
  } irq_mode_e;

  localparam int IDX_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  localparam logic [15:0] ADDR_VERSION = 16'h0000;
  localparam logic [15:0] ADDR_ROUTER  = 16'h0004;
  localparam logic [15:0] ADDR_STATUS  = 16'h0008;
  localparam logic [15:0] ADDR_MASK    = 16'h000C;
  localparam logic [15:0] ADDR_MODE    = 16'h0010;
  localparam logic [15:0] ADDR_TIMEOUT = 16'h0014;
  localparam logic [15:0] ADDR_RAW     = 16'h0018;
  localparam logic [15:0] THR_BASE     = 16'h0020;
  localparam logic [15:0] THR_END      = 16'(32 + 4 * NUM_VC);
  localparam logic [15:0] PKT_BASE     = 16'h0040;
  localparam logic [15:0] PKT_END      = 16'(64 + 4 * NUM_VC);

  // State
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            resp_rdata_q, resp_rdata_d;
  logic                   resp_error_q, resp_error_d;
  logic [NUM_VC-1:0]      status_q, status_d;
  logic [NUM_VC-1:0]      raw_q, raw_d;
  logic [NUM_VC-1:0]      mask_q, mask_d;
  irq_mode_e              mode_q, mode_d;
  logic [TIMER_WIDTH-1:0] timeout_q, timeout_d;
  logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;
  logic [OCUP_WIDTH-1:0]  thresh_q [NUM_VC];
  logic [OCUP_WIDTH-1:0]  thresh_d [NUM_VC];

  // Decode results
  logic [OCUP_WIDTH-1:0]  ocup_arr [NUM_VC];
  logic [PKT_WIDTH-1:0]   pkt_arr  [NUM_VC];
  logic [NUM_VC-1:0]      raw;
  logic [NUM_VC-1:0]      pending;
  logic [NUM_VC-1:0]      clr_bits;
  logic [IDX_W-1:0]       idx;
  logic                   accept, do_wr;
  logic                   mask_we, mode_we, timeout_we, thr_we;
  logic [31:0]            acc_rdata;
  logic                   acc_err;
  logic                   unused_wdata;

  // Upper write-data bits are architecturally ignored.
  assign unused_wdata = ^req_wdata_i;

  assign req_ready_o  = ~resp_valid_q | resp_ready_i;
  assign accept       = req_valid_i & req_ready_o;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_error_o = resp_error_q;

  // Raw per-VC condition, selected by the current mode.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      ocup_arr[i] = ocup_i[i*OCUP_WIDTH +: OCUP_WIDTH];
      pkt_arr[i]  = pkt_size_i[i*PKT_WIDTH +: PKT_WIDTH];
      unique case (mode_q)
        MODE_FULL:   raw[i] = full_i[i];
        MODE_THRESH: raw[i] = (ocup_arr[i] >= thresh_q[i]);
        default:     raw[i] = ~empty_i[i];
      endcase
    end
  end

  assign pending   = status_q & mask_q;
  assign irq_vcs_o = pending;
  // With a zero timeout the interrupt follows pending directly; otherwise it
  // waits until pending has been continuously non-zero for timeout cycles.
  assign irq_o = (|pending) & ((timeout_q == '0) | (cnt_q >= timeout_q));

  // Address decode. Read data is taken from current (pre-write) state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    acc_rdata  = '0;
    acc_err    = 1'b0;
    clr_bits   = '0;
    mask_we    = 1'b0;
    mode_we    = 1'b0;
    timeout_we = 1'b0;
    thr_we     = 1'b0;
    // Both per-VC windows start on 32-byte boundaries, so the VC index sits
    // directly in the word-address bits.
    idx        = req_addr_i[2 +: IDX_W];
    if (req_addr_i[1:0] != 2'b00) begin
      acc_err = 1'b1;
    end else if (req_addr_i >= THR_BASE && req_addr_i < THR_END) begin
      if (req_wr_i) thr_we = 1'b1;
      else          acc_rdata = 32'(thresh_q[idx]);
    end else if (req_addr_i >= PKT_BASE && req_addr_i < PKT_END) begin
      if (req_wr_i) acc_err = 1'b1;
      else          acc_rdata = 32'(pkt_arr[idx]);
    end else begin
      unique case (req_addr_i)
        ADDR_VERSION: if (req_wr_i) acc_err = 1'b1; else acc_rdata = VERSION;
        ADDR_ROUTER:  if (req_wr_i) acc_err = 1'b1; else acc_rdata = {ROUTER_Y_ID, ROUTER_X_ID};
        ADDR_STATUS:  if (req_wr_i) clr_bits = req_wdata_i[NUM_VC-1:0];
                      else acc_rdata = 32'(status_q);
        ADDR_MASK:    if (req_wr_i) mask_we = 1'b1; else acc_rdata = 32'(mask_q);
        ADDR_MODE: begin
          if (req_wr_i) begin
            if (req_wdata_i[1:0] == 2'b11) acc_err = 1'b1;
            else                           mode_we = 1'b1;
          end else begin
            acc_rdata = 32'(mode_q);
          end
        end
        ADDR_TIMEOUT: if (req_wr_i) timeout_we = 1'b1; else acc_rdata = 32'(timeout_q);
        ADDR_RAW:     if (req_wr_i) acc_err = 1'b1; else acc_rdata = 32'(raw);
        default:      acc_err = 1'b1;
      endcase
    end
  end

  assign do_wr = accept & req_wr_i & ~acc_err;

  // Next-state logic.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = acc_rdata;
      resp_error_d = acc_err;
    end else if (resp_ready_i) begin
      resp_valid_d = 1'b0;
    end

    raw_d = raw;
    // Clear is applied before the set term, so a same-cycle rising edge wins.
    status_d  = (status_q & ~(do_wr ? clr_bits : '0)) | (raw & ~raw_q);
    mask_d    = (do_wr & mask_we) ? req_wdata_i[NUM_VC-1:0] : mask_q;
    mode_d    = (do_wr & mode_we) ? irq_mode_e'(req_wdata_i[1:0]) : mode_q;
    timeout_d = (do_wr & timeout_we) ? req_wdata_i[TIMER_WIDTH-1:0] : timeout_q;

    thresh_d = thresh_q;
    if (do_wr & thr_we) thresh_d[idx] = req_wdata_i[OCUP_WIDTH-1:0];

    if (|pending) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    else          cnt_d = '0;
  end

  always_ff @(posedge clk_axi or negedge arst_axi_n) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (!arst_axi_n) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      status_q     <= '0;
      raw_q        <= '0;
      mask_q       <= '1;
      mode_q       <= MODE_NOT_EMPTY;
      timeout_q    <= '0;
      cnt_q        <= '0;
      // NOTE: the threshold array is a handful of software-visible registers
      // with a defined reset value, so it is reset like any flop (it is not a
      // RAM and must not be mapped to one).
      for (int i = 0; i < NUM_VC; i++) thresh_q[i] <= '1;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      status_q     <= status_d;
      raw_q        <= raw_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
      for (int i = 0; i < NUM_VC; i++) thresh_q[i] <= thresh_d[i];
    end
  end

endmodule

// File: tb/tb_ni_csr_irq_ctrl.sv
// tb_ni_csr_irq_ctrl
//   Directed scenarios followed by randomized traffic. A cycle-level
//   behavioural model predicts outputs each cycle and pushes expected read
//   responses into a queue; a separate monitor pops and compares whenever
//   the DUT presents a response.
module tb_ni_csr_irq_ctrl;
  localparam int NV  = 4;
  localparam int OW  = 16;
  localparam int PW  = 8;
  localparam int TW  = 16;
  localparam int CNT_MAX = (1 << TW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid_i, req_ready_o, req_wr_i;
  logic [15:0]     req_addr_i;
  logic [31:0]     req_wdata_i;
  logic            resp_valid_o, resp_ready_i, resp_error_o;
  logic [31:0]     resp_rdata_o;
  logic [NV-1:0]   empty_i, full_i, irq_vcs_o;
  logic [NV*OW-1:0] ocup_i;
  logic [NV*PW-1:0] pkt_size_i;
  logic            irq_o;

  ni_csr_irq_ctrl #(
    .NUM_VC(NV), .OCUP_WIDTH(OW), .PKT_WIDTH(PW), .TIMER_WIDTH(TW),
    .ROUTER_X_ID(16'd2), .ROUTER_Y_ID(16'd3), .VERSION(32'h0002_0000)
  ) dut (
    .clk_axi(clk), .arst_axi_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_error_o(resp_error_o),
    .empty_i(empty_i), .full_i(full_i), .ocup_i(ocup_i), .pkt_size_i(pkt_size_i),
    .irq_vcs_o(irq_vcs_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t exp_q[$];

  // Behavioural model state
  logic [NV-1:0] m_status, m_rawq, m_mask;
  int            m_mode, m_tout, m_cnt;
  int            m_thr[NV];
  bit            m_rv;

  // Model: predicts this cycle's outputs, then advances one cycle.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      m_status = '0; m_rawq = '0; m_mask = '1; m_mode = 0; m_tout = 0; m_cnt = 0;
      foreach (m_thr[i]) m_thr[i] = CNT_MAX;
      m_rv = 1'b0;
      exp_q.delete();
      check("rst_req_ready", req_ready_o, 1);
      check("rst_resp_valid", resp_valid_o, 0);
      check("rst_rdata", resp_rdata_o, 0);
      check("rst_error", resp_error_o, 0);
      check("rst_irq_vcs", irq_vcs_o, 0);
      check("rst_irq", irq_o, 0);
    end else begin
      logic [NV-1:0] raw, pend, clr;
      bit            ready, acc, exp_irq;
      resp_t         r;
      int            a, idx;
      logic [31:0]   wd;
      for (int i = 0; i < NV; i++) begin
        if (m_mode == 0)      raw[i] = !empty_i[i];
        else if (m_mode == 1) raw[i] = full_i[i];
        else                  raw[i] = (int'(ocup_i[i*OW +: OW]) >= m_thr[i]);
      end
      pend    = m_status & m_mask;
      exp_irq = (pend != 0) && (m_tout == 0 || m_cnt >= m_tout);
      ready   = !m_rv || resp_ready_i;
      check("irq_vcs", irq_vcs_o, pend);
      check("irq", irq_o, exp_irq);
      check("req_ready", req_ready_o, ready);
      check("resp_valid", resp_valid_o, m_rv);

      clr = '0;
      acc = req_valid_i && ready;
      if (acc) begin
        a = int'(req_addr_i);
        wd = req_wdata_i;
        r.rdata = 0;
        r.err   = 1'b0;
        if (a % 4 != 0) r.err = 1'b1;
        else if (a >= 32 && a < 32 + 4*NV) begin
          idx = (a - 32) / 4;
          if (req_wr_i) m_thr[idx] = int'(wd[OW-1:0]);
          else          r.rdata = m_thr[idx];
        end else if (a >= 64 && a < 64 + 4*NV) begin
          idx = (a - 64) / 4;
          if (req_wr_i) r.err = 1'b1;
          else          r.rdata = 32'(pkt_size_i[idx*PW +: PW]);
        end else begin
          case (a)
            0:  if (req_wr_i) r.err = 1'b1; else r.rdata = 32'h0002_0000;
            4:  if (req_wr_i) r.err = 1'b1; else r.rdata = 32'h0003_0002;
            8:  if (req_wr_i) clr = wd[NV-1:0]; else r.rdata = 32'(m_status);
            12: if (req_wr_i) m_mask = wd[NV-1:0]; else r.rdata = 32'(m_mask);
            16: if (req_wr_i) begin
                  if (wd[1:0] == 2'b11) r.err = 1'b1;
                  else m_mode = int'(wd[1:0]);
                end else r.rdata = m_mode;
            20: if (req_wr_i) m_tout = int'(wd[TW-1:0]); else r.rdata = m_tout;
            24: if (req_wr_i) r.err = 1'b1; else r.rdata = 32'(raw);
            default: r.err = 1'b1;
          endcase
        end
        exp_q.push_back(r);
      end
      m_status = (m_status & ~clr) | (raw & ~m_rawq);
      m_rawq   = raw;
      m_cnt    = (pend != 0) ? ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1) : 0;
      if (acc)               m_rv = 1'b1;
      else if (resp_ready_i) m_rv = 1'b0;
    end
  end

  // Monitor: compares every presented response against the queue head,
  // popping on handshake (so held responses are checked for stability).
  always begin
    @(negedge clk);
    if (rst_n && resp_valid_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected: got rdata %h err %0b, expected none", resp_rdata_o, resp_error_o);
      end else begin
        check("resp_rdata", resp_rdata_o, exp_q[0].rdata);
        check("resp_error", resp_error_o, exp_q[0].err);
        if (resp_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request; entered and left at posedge+1.
  task automatic req(input bit wr, input logic [15:0] a, input logic [31:0] d);
    int budget = 50;
    req_valid_i = 1'b1; req_wr_i = wr; req_addr_i = a; req_wdata_i = d;
    forever begin
      @(negedge clk);
      if (req_ready_o) break;
      budget--;
      if (budget == 0) begin
        total++;
        bad++;
        $display("FAIL req_timeout: got no ready, expected ready within 50 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic set_ocup(input int i, input int v);
    ocup_i[i*OW +: OW] = OW'(v);
  endtask

  int alist[20] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 44, 60, 64, 68, 76, 92, 2, 9, 96};

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_wr_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    resp_ready_i = 1'b1;
    empty_i = '1; full_i = '0; ocup_i = '0; pkt_size_i = 32'h4433_2211;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // ID / default registers
    req(0, 16'h0000, 0);
    req(0, 16'h0004, 0);
    req(0, 16'h000C, 0);
    req(0, 16'h0044, 0);
    // Error accesses, then confirm nothing changed
    req(1, 16'h0000, 32'h1234);
    req(0, 16'h003C, 0);
    req(0, 16'h0002, 0);
    req(1, 16'h0010, 3);
    req(1, 16'h0048, 5);
    req(0, 16'h0010, 0);
    req(0, 16'h0020, 0);

    // Mode 0: buffer 1 becomes non-empty
    empty_i[1] = 1'b0;
    cyc(2);
    req(0, 16'h0008, 0);
    req(1, 16'h0008, 2);
    cyc(2);
    req(0, 16'h0008, 0);
    empty_i[1] = 1'b1; cyc(2);
    empty_i[1] = 1'b0; cyc(2);
    req(0, 16'h0018, 0);
    req(1, 16'h0008, 32'hF);

    // Mode 2: threshold on VC0, then mask it off
    req(1, 16'h0020, 5);
    req(1, 16'h0010, 2);
    set_ocup(0, 4); cyc(2);
    set_ocup(0, 5); cyc(2);
    req(1, 16'h000C, 32'hE);
    cyc(2);
    req(0, 16'h0008, 0);
    req(1, 16'h0008, 32'hF);
    req(1, 16'h000C, 32'hF);
    set_ocup(0, 0);

    // Coalescing with timeout 3 in mode 1
    req(1, 16'h0014, 3);
    req(1, 16'h0010, 1);
    full_i[2] = 1'b1; cyc(6);
    full_i[2] = 1'b0;
    req(1, 16'h0008, 4);
    cyc(2);
    full_i[2] = 1'b1; cyc(1);
    req(1, 16'h0008, 4);
    cyc(6);
    full_i[2] = 1'b0;
    req(1, 16'h0014, 0);

    // Same-cycle W1C and rising edge on bit 0: set wins
    full_i[0] = 1'b1; cyc(2);
    full_i[0] = 1'b0; cyc(2);
    full_i[0] = 1'b1;
    req(1, 16'h0008, 1);
    cyc(1);
    req(0, 16'h0008, 0);

    // Back-pressure on the response channel
    cyc(1);
    resp_ready_i = 1'b0;
    req(0, 16'h0004, 0);
    cyc(4);
    resp_ready_i = 1'b1;
    cyc(2);

    // Reset with a response pending
    resp_ready_i = 1'b0;
    req(0, 16'h0000, 0);
    cyc(1);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    resp_ready_i = 1'b1;
    cyc(2);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      resp_ready_i = ($urandom_range(0, 3) != 0);
      req_valid_i  = ($urandom_range(0, 2) == 0);
      req_wr_i     = $urandom_range(0, 1);
      req_addr_i   = 16'(alist[$urandom_range(0, 19)]);
      req_wdata_i  = ($urandom_range(0, 4) != 0) ? 32'($urandom_range(0, 7)) : $urandom;
      for (int i = 0; i < NV; i++) begin
        if ($urandom_range(0, 7) == 0) empty_i[i] = ~empty_i[i];
        if ($urandom_range(0, 7) == 0) full_i[i]  = ~full_i[i];
        set_ocup(i, $urandom_range(0, 7));
      end
      pkt_size_i = $urandom;
      cyc(1);
    end

    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    cyc(5);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
